elevator_call_scheduler: RTL and testbench
==========================================

Name: elevator_call_scheduler

Overview:
Sequences the four-floor elevator car. Holds pending floor calls in a 4-entry ordered call memory whose entry 0 is the current target. Applies the same-direction, in-between head-insertion rule to each new call. Runs a travel/door state machine that drives the motor and door outputs and tracks the actual floor.

Parameters:
TRAVEL_CYCLES, 8, clock cycles to travel one floor (≥2)
DOOR_CYCLES, 6, clock cycles the door stays open (≥2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
call_valid  input  1  one-cycle strobe: new floor call present
call_floor  input  2  requested floor 0..3
call_dir  input  1  requested direction, 1 = up, 0 = down
call_ack  output  1  call accepted this cycle (combinational from inputs + state)
actual_floor  output  2  current car floor
dir_up  output  1  current travel direction flag, 1 = up
motor_up  output  1  car moving up
motor_down  output  1  car moving down
door_open  output  1  door open
pending_count  output  3  number of valid call memory entries, 0..4
busy  output  1  state ≠ IDLE or pending_count ≠ 0

Behaviour:
- Reset values:
  - state IDLE, queue and count 0, actual_floor 0, dir_up 1, timer 0.
  - All motor, door and ack outputs 0.
  - Reset mid-travel or mid-door drops all calls immediately and returns the car to floor 0 logically.
- Call memory:
  - Entries e0..e3; e0 is the head (target).
  - Entries are always distinct, so count ≤ 4 and "full" implies that any call is a duplicate.
- Call acceptance (evaluated every cycle with call_valid=1):
  - Rejected (call_ack=0, no change) if call_floor matches any valid entry.
  - Rejected if call_floor == actual_floor while state is DOOR.
  - If state is IDLE, call_floor == actual_floor and count = 0, the call is accepted and the next state is DOOR. Nothing is stored.
  - Head insertion occurs when state is MOVING, call_dir == dir_up, and call_floor lies strictly between actual_floor and e0 (either ordering). The call goes to e0 and existing entries shift down by one.
  - Otherwise the call is appended at the tail.
- FSM:
  - IDLE:
    - If count > 0 and e0 == actual_floor: pop e0 and go to DOOR.
    - If count > 0 and e0 ≠ actual_floor: dir_up = (e0 > actual_floor), timer = TRAVEL_CYCLES−1, go to MOVING.
  - MOVING:
    - motor_up = dir_up and motor_down = ~dir_up, asserted throughout the state.
    - Timer decrements each cycle.
    - When timer = 0, actual_floor steps ±1 on that edge.
    - If the new floor == e0: pop e0, timer = DOOR_CYCLES−1, go to DOOR.
    - Otherwise reload the timer and stay in MOVING.
  - DOOR:
    - door_open = 1.
    - Timer decrements; when timer = 0, go to IDLE.
    - Door open duration is exactly DOOR_CYCLES cycles. Travel per floor is exactly TRAVEL_CYCLES cycles.
- Simultaneous events:
  - In a cycle where a pop occurs, pop first, then process the call against the shifted memory.
  - Head insertion is disabled in a pop cycle; the call is appended at the tail.
- Arithmetic:
  - actual_floor never wraps; a step is only taken toward e0, which is within 0..3.
  - pending_count saturates naturally at 4.
- Direction:
  - dir_up changes only when leaving IDLE.
  - dir_up holds its last value while in DOOR and IDLE.
- Latency:
  - A call accepted in IDLE, for a different floor, asserts the motor on the 2nd edge after acceptance.
  - Door opening follows the arrival edge with no extra cycle.

Test Plan:
- Reset then call_floor=2, dir=1 at t0 → ack=1, count=1. motor_up asserted for 16 cycles. actual_floor 0→1→2. Door open for 6 cycles, then IDLE, count=0, busy=0.
- Car at 0 moving up to 3; call floor 1, dir=1 issued while actual_floor=0 → head insertion. Car stops at 1 (door 6 cycles), then continues to 3.
- Same as above but call floor 1 with dir=0 → tail append. Car goes 0→3, stops, then dir_up=0 and returns to 1.
- Duplicate call for a floor already pending, and a call for actual_floor while the door is open → ack=0, count unchanged.
- Call arriving in the exact arrival/pop cycle that satisfies the between rule → appended at the tail, not the head. Verify the resulting order in the call memory.
- Assert reset during MOVING between floors 1 and 2 → all outputs 0 immediately, actual_floor=0, count=0. The next call proceeds normally from floor 0.

Source files
------------

// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - four-floor elevator call memory and travel/door sequencer
// Entry 0 of the call memory is always the current target floor.
module elevator_call_scheduler #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       call_valid,
  input  logic [1:0] call_floor,
  input  logic       call_dir,
  output logic       call_ack,
  output logic [1:0] actual_floor,
  output logic       dir_up,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic [2:0] pending_count,
  output logic       busy
);

  localparam int TW = $clog2(TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MOVING = 2'd1;
  localparam logic [1:0] S_DOOR   = 2'd2;

  logic [1:0]      state;
  logic [TW-1:0]   timer;
  logic [3:0][1:0] q;
  logic [2:0]      count;

  logic [3:0][1:0] sq, nq;
  logic [2:0]      scount, ncount;
  logic [1:0]      next_floor;
  logic            step, pop, dup, idle_here, between, head;

  always_comb begin
    next_floor = dir_up ? actual_floor + 2'd1 : actual_floor - 2'd1;
    step       = (state == S_MOVING) && (timer == '0);
    pop        = (count != 3'd0) &&
                 (((state == S_IDLE) && (q[0] == actual_floor)) ||
                  (step && (next_floor == q[0])));
    // Duplicates are judged against the memory before any pop, so a call
    // for the floor being serviced this cycle is not re-queued.
    dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < count) && (q[i] == call_floor)) dup = 1'b1;
    end
    idle_here = (state == S_IDLE) && (count == 3'd0) && (call_floor == actual_floor);
    call_ack  = call_valid && !dup && !((state == S_DOOR) && (call_floor == actual_floor));
    between   = ((call_floor > actual_floor) && (call_floor < q[0])) ||
                ((call_floor < actual_floor) && (call_floor > q[0]));
    head      = (state == S_MOVING) && !pop && (call_dir == dir_up) && between;

    sq     = pop ? {2'd0, q[3:1]} : q;
    scount = pop ? count - 3'd1 : count;
    nq     = sq;
    ncount = scount;
    if (call_ack && !idle_here) begin
      if (head) nq = {sq[2:0], call_floor};
      else      nq[scount[1:0]] = call_floor;
      ncount = scount + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      timer        <= '0;
      q            <= '0;
      count        <= 3'd0;
      actual_floor <= 2'd0;
      dir_up       <= 1'b1;
    end else begin
      q     <= nq;
      count <= ncount;
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_DOOR;
            timer <= DOOR_LOAD;
          end else if (count != 3'd0) begin
            dir_up <= (q[0] > actual_floor);
            timer  <= TRAVEL_LOAD;
            state  <= S_MOVING;
          end else if (call_ack && idle_here) begin
            state <= S_DOOR;
            timer <= DOOR_LOAD;
          end
        end
        S_MOVING: begin
          if (step) begin
            actual_floor <= next_floor;
            if (pop) begin
              state <= S_DOOR;
              timer <= DOOR_LOAD;
            end else begin
              timer <= TRAVEL_LOAD;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DOOR: begin
          if (timer == '0) state <= S_IDLE;
          else             timer <= timer - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign motor_up      = (state == S_MOVING) && dir_up;
  assign motor_down    = (state == S_MOVING) && !dir_up;
  assign door_open     = (state == S_DOOR);
  assign pending_count = count;
  assign busy          = (state != S_IDLE) || (count != 3'd0);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - directed self-checking bench for elevator_call_scheduler
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       call_valid;
  logic [1:0] call_floor;
  logic       call_dir;
  logic       call_ack;
  logic [1:0] actual_floor;
  logic       dir_up, motor_up, motor_down, door_open, busy;
  logic [2:0] pending_count;

  int tests_run = 0;
  int tests_failed = 0;

  elevator_call_scheduler #(.TRAVEL_CYCLES(8), .DOOR_CYCLES(6)) dut (
    .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .call_dir(call_dir), .call_ack(call_ack), .actual_floor(actual_floor),
    .dir_up(dir_up), .motor_up(motor_up), .motor_down(motor_down),
    .door_open(door_open), .pending_count(pending_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    call_valid = 1'b0;
    call_floor = 2'd0;
    call_dir = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Presents a call for exactly one edge and returns the combinational ack.
  task automatic call(input logic [1:0] f, input logic d, output logic ack);
    call_valid = 1'b1;
    call_floor = f;
    call_dir = d;
    #1;
    ack = call_ack;
    tick();
    call_valid = 1'b0;
  endtask

  task automatic wait_door(input string tag);
    int n = 0;
    while (!door_open && n < 200) begin
      tick();
      n++;
    end
    check(tag, int'(door_open), 1);
  endtask

  task automatic wait_close(input string tag);
    int n = 0;
    while (door_open && n < 50) begin
      tick();
      n++;
    end
    check(tag, int'(door_open), 0);
  endtask

  initial begin
    logic ack;
    int cnt;

    do_reset();
    check("rst_count", int'(pending_count), 0);
    check("rst_floor", int'(actual_floor), 0);
    check("rst_dir", int'(dir_up), 1);
    check("rst_outs", int'({motor_up, motor_down, door_open, busy, call_ack}), 0);

    // Single trip 0 -> 2
    call(2'd2, 1'b1, ack);
    check("t1_ack", int'(ack), 1);
    check("t1_count", int'(pending_count), 1);
    check("t1_motor_e1", int'(motor_up), 0);
    tick();
    check("t1_motor_e2", int'(motor_up), 1);
    cnt = 0;
    while (motor_up && cnt < 100) begin
      cnt++;
      tick();
    end
    check("t1_motor_cycles", cnt, 16);
    check("t1_door", int'(door_open), 1);
    check("t1_floor", int'(actual_floor), 2);
    check("t1_count0", int'(pending_count), 0);
    cnt = 0;
    while (door_open && cnt < 100) begin
      cnt++;
      tick();
    end
    check("t1_door_cycles", cnt, 6);
    check("t1_busy", int'(busy), 0);

    // Head insertion: heading to 3, same-direction call for 1
    do_reset();
    call(2'd3, 1'b1, ack);
    tick();
    call(2'd1, 1'b1, ack);
    check("t2_ack", int'(ack), 1);
    check("t2_count", int'(pending_count), 2);
    wait_door("t2_door1");
    check("t2_floor1", int'(actual_floor), 1);
    wait_close("t2_close1");
    wait_door("t2_door2");
    check("t2_floor2", int'(actual_floor), 3);
    check("t2_count0", int'(pending_count), 0);

    // Opposite-direction call is appended; duplicates and door-floor calls rejected
    do_reset();
    call(2'd3, 1'b1, ack);
    tick();
    call(2'd1, 1'b0, ack);
    check("t3_ack", int'(ack), 1);
    check("t3_count", int'(pending_count), 2);
    call(2'd3, 1'b1, ack);
    check("t4_dup_ack", int'(ack), 0);
    check("t4_dup_count", int'(pending_count), 2);
    wait_door("t3_door1");
    check("t3_floor1", int'(actual_floor), 3);
    check("t3_dir1", int'(dir_up), 1);
    call(2'd3, 1'b0, ack);
    check("t4_door_ack", int'(ack), 0);
    call(2'd1, 1'b1, ack);
    check("t4_dup2_ack", int'(ack), 0);
    check("t4_count", int'(pending_count), 1);
    wait_close("t3_close1");
    wait_door("t3_door2");
    check("t3_floor2", int'(actual_floor), 1);
    check("t3_dir2", int'(dir_up), 0);
    check("t3_count0", int'(pending_count), 0);

    // Call landing on the pop edge goes to the tail: memory becomes [3,2]
    do_reset();
    call(2'd1, 1'b1, ack);
    call(2'd3, 1'b1, ack);
    check("t5_motor", int'(motor_up), 1);
    for (int i = 0; i < 7; i++) tick();
    check("t5_pre_floor", int'(actual_floor), 0);
    call(2'd2, 1'b1, ack);
    check("t5_ack", int'(ack), 1);
    check("t5_door", int'(door_open), 1);
    check("t5_floor", int'(actual_floor), 1);
    check("t5_count", int'(pending_count), 2);
    wait_close("t5_close1");
    wait_door("t5_door2");
    check("t5_order_first", int'(actual_floor), 3);
    wait_close("t5_close2");
    wait_door("t5_door3");
    check("t5_order_second", int'(actual_floor), 2);
    check("t5_dir", int'(dir_up), 0);

    // Asynchronous reset mid-travel between floors 1 and 2
    do_reset();
    call(2'd3, 1'b1, ack);
    tick();
    for (int i = 0; i < 8; i++) tick();
    check("t6_floor1", int'(actual_floor), 1);
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("t6_outs", int'({motor_up, motor_down, door_open, busy}), 0);
    check("t6_floor", int'(actual_floor), 0);
    check("t6_count", int'(pending_count), 0);
    reset = 1'b0;
    tick();
    call(2'd1, 1'b1, ack);
    check("t6_ack", int'(ack), 1);
    wait_door("t6_door");
    check("t6_floor_after", int'(actual_floor), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
